// File: rtl/riscv_pkg.sv
// Shared RISC-V types for the core pipeline.
// Holds opcodes, branch funct3 codes and the BTB entry layout.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_branch_e;

  // Weakly not-taken.
  localparam logic [1:0] CNT_INIT_DEF = 2'b01;

  // Tag is kept zero-extended to XLEN.
  typedef struct packed {
    logic            valid;
    logic            is_jump;
    logic [1:0]      cnt;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator for EX.
// Unknown funct3 codes evaluate to not-taken.
module branch_cond
  import riscv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  funct3_branch_e funct3_i,
  input  logic [W-1:0]   rs1_i,
  input  logic [W-1:0]   rs2_i,
  output logic           cond_o
);

  // Compare operands per funct3.
  always_comb begin
    cond_o = 1'b0;
    unique case (funct3_i)
      F3_BEQ:  cond_o = rs1_i == rs2_i;
      F3_BNE:  cond_o = rs1_i != rs2_i;
      F3_BLT:  cond_o = $signed(rs1_i) < $signed(rs2_i);
      F3_BGE:  cond_o = $signed(rs1_i) >= $signed(rs2_i);
      F3_BLTU: cond_o = rs1_i < rs2_i;
      F3_BGEU: cond_o = rs1_i >= rs2_i;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// BTB predictor (IF lookup) plus branch resolver (EX update).
// Optional BPU_PERF_EN adds branch/mispredict counters.
module branch_predict_unit
  import riscv_pkg::opcode_e;
  import riscv_pkg::funct3_branch_e;
  import riscv_pkg::btb_entry_t;
#(
  parameter int         XLEN        = riscv_pkg::XLEN,
  parameter int         BTB_ENTRIES = 64,
  parameter logic [1:0] CNT_INIT    = riscv_pkg::CNT_INIT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  input  logic            ex_valid,
  input  opcode_e         ex_opcode,
  input  funct3_branch_e  ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            ex_taken,
  output logic [XLEN-1:0] ex_target,
  output logic [XLEN-1:0] ex_link,
  output logic            ex_mispredict,
  output logic [XLEN-1:0] ex_redirect_pc
`ifdef BPU_PERF_EN
  ,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispredicts
`endif
);

  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDXW - 2;

  btb_entry_t btb_q [BTB_ENTRIES];

  logic [IDXW-1:0] if_idx, ex_idx;
  logic [XLEN-1:0] if_tag, ex_tag;
  btb_entry_t      if_ent;
  logic            if_hit, ex_hit;

  assign if_idx = if_pc[IDXW+1:2];
  assign ex_idx = ex_pc[IDXW+1:2];
  assign if_tag = {{(IDXW+2){1'b0}}, if_pc[XLEN-1:IDXW+2]};
  assign ex_tag = {{(IDXW+2){1'b0}}, ex_pc[XLEN-1:IDXW+2]};

  assign if_ent = btb_q[if_idx];
  assign if_hit = if_ent.valid && (if_ent.tag == if_tag);
  assign ex_hit = btb_q[ex_idx].valid
               && (btb_q[ex_idx].tag == ex_tag);

  assign if_pred_taken  = if_hit
                       && (if_ent.cnt[1] || if_ent.is_jump);
  assign if_pred_target = if_pred_taken ? if_ent.target
                                        : if_pc + XLEN'(4);

  logic is_br, is_jal, is_jalr, is_ctrl, cond;
  logic [XLEN-1:0] jalr_sum;

  assign is_br   = ex_opcode == riscv_pkg::OP_BRANCH;
  assign is_jal  = ex_opcode == riscv_pkg::OP_JAL;
  assign is_jalr = ex_opcode == riscv_pkg::OP_JALR;
  assign is_ctrl = is_br || is_jal || is_jalr;

  assign jalr_sum = ex_rs1_data + ex_imm;

  branch_cond #(.W(XLEN)) u_cond (
    .funct3_i (ex_funct3),
    .rs1_i    (ex_rs1_data),
    .rs2_i    (ex_rs2_data),
    .cond_o   (cond)
  );

  // Resolve the EX instruction; everything reads 0 when idle.
  always_comb begin
    ex_taken       = 1'b0;
    ex_target      = '0;
    ex_link        = '0;
    ex_mispredict  = 1'b0;
    ex_redirect_pc = '0;
    if (ex_valid) begin
      ex_link = ex_pc + XLEN'(4);
      unique case (1'b1)
        is_jal: begin
          ex_taken  = 1'b1;
          ex_target = ex_pc + ex_imm;
        end
        is_jalr: begin
          ex_taken  = 1'b1;
          ex_target = {jalr_sum[XLEN-1:1], 1'b0};
        end
        is_br: begin
          ex_taken  = cond;
          ex_target = ex_pc + ex_imm;
        end
        default: begin
          ex_taken  = 1'b0;
          ex_target = '0;
        end
      endcase
      ex_mispredict = (ex_taken != ex_pred_taken)
                   || (ex_taken
                       && ex_target != ex_pred_target);
      ex_redirect_pc = ex_taken ? ex_target : ex_link;
    end
  end

  logic [1:0] cnt_d;
  btb_entry_t alloc_d;

  // Saturating counter step and fresh entry contents.
  always_comb begin
    cnt_d = btb_q[ex_idx].cnt;
    if (ex_taken && cnt_d != 2'b11) begin
      cnt_d = cnt_d + 2'b01;
    end else if (!ex_taken && cnt_d != 2'b00) begin
      cnt_d = cnt_d - 2'b01;
    end
    alloc_d = '{
      valid:   1'b1,
      is_jump: is_jal || is_jalr,
      cnt:     CNT_INIT,
      tag:     ex_tag,
      target:  ex_target
    };
  end

  // Train on control flow; drop stale hits on non-control.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i].valid   <= 1'b0;
        btb_q[i].is_jump <= 1'b0;
        btb_q[i].cnt     <= CNT_INIT;
      end
    end else if (ex_valid && is_ctrl) begin
      if (ex_hit) begin
        btb_q[ex_idx].cnt <= cnt_d;
        if (ex_taken) begin
          btb_q[ex_idx].target <= ex_target;
        end
      end else if (ex_taken) begin
        btb_q[ex_idx] <= alloc_d;
      end
    end else if (ex_valid && ex_pred_taken && ex_hit) begin
      btb_q[ex_idx].valid <= 1'b0;
    end
  end

`ifdef BPU_PERF_EN
  logic [31:0] perf_br_q, perf_br_d;
  logic [31:0] perf_mp_q, perf_mp_d;

  // Saturating event counts.
  always_comb begin
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (ex_valid && is_ctrl && perf_br_q != 32'hFFFF_FFFF) begin
      perf_br_d = perf_br_q + 32'd1;
    end
    if (ex_mispredict && perf_mp_q != 32'hFFFF_FFFF) begin
      perf_mp_d = perf_mp_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit.
// Directed scenarios, then random traffic vs a table model.
module tb_branch_predict_unit;
  import riscv_pkg::*;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid = 1'b0;
  opcode_e     ex_opcode = OP_OP;
  funct3_branch_e ex_funct3 = F3_BEQ;
  logic [31:0] ex_pc = '0;
  logic [31:0] ex_rs1_data = '0;
  logic [31:0] ex_rs2_data = '0;
  logic [31:0] ex_imm = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [31:0] ex_link;
  logic        ex_mispredict;
  logic [31:0] ex_redirect_pc;
`ifdef BPU_PERF_EN
  logic [31:0] perf_branches;
  logic [31:0] perf_mispredicts;
  logic [31:0] m_pb, m_pm;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .ex_valid       (ex_valid),
    .ex_opcode      (ex_opcode),
    .ex_funct3      (ex_funct3),
    .ex_pc          (ex_pc),
    .ex_rs1_data    (ex_rs1_data),
    .ex_rs2_data    (ex_rs2_data),
    .ex_imm         (ex_imm),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_link        (ex_link),
    .ex_mispredict  (ex_mispredict),
    .ex_redirect_pc (ex_redirect_pc)
`ifdef BPU_PERF_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  // Reference table: one record per index.
  bit          m_v [N];
  bit          m_j [N];
  int          m_c [N];
  int unsigned m_t [N];
  logic [31:0] m_g [N];

  logic        obs_pt, obs_tk, obs_mp;
  logic [31:0] obs_ptg, obs_tg, obs_ln, obs_rd;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic int unsigned mtag(input logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  function automatic bit mhit(input logic [31:0] pc);
    return m_v[midx(pc)] && m_t[midx(pc)] == mtag(pc);
  endfunction

  function automatic bit m_pt(input logic [31:0] pc);
    return mhit(pc) && (m_c[midx(pc)] >= 2 || m_j[midx(pc)]);
  endfunction

  function automatic logic [31:0] m_ptg(input logic [31:0] pc);
    return m_pt(pc) ? m_g[midx(pc)] : pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0;
      m_j[i] = 0;
      m_c[i] = 1;
    end
`ifdef BPU_PERF_EN
    m_pb = 0;
    m_pm = 0;
`endif
  endtask

  task automatic step(input logic r, input logic [31:0] ipc,
                      input logic v, input opcode_e op,
                      input logic [2:0] f3,
                      input logic [31:0] pc,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] imm,
                      input logic pt,
                      input logic [31:0] ptg);
    bit ctrl, tk, mp;
    logic [31:0] tg, ln, rd;
    int i;
    @(negedge clk);
    rst = r;
    if_pc = ipc;
    ex_valid = v;
    ex_opcode = op;
    ex_funct3 = funct3_branch_e'(f3);
    ex_pc = pc;
    ex_rs1_data = a;
    ex_rs2_data = b;
    ex_imm = imm;
    ex_pred_taken = pt;
    ex_pred_target = ptg;
    #1;
    ctrl = op == OP_BRANCH || op == OP_JAL || op == OP_JALR;
    tk = 0;
    tg = 0;
    if (op == OP_BRANCH) begin
      tg = pc + imm;
      case (f3)
        3'd0: tk = a == b;
        3'd1: tk = a != b;
        3'd4: tk = $signed(a) < $signed(b);
        3'd5: tk = $signed(a) >= $signed(b);
        3'd6: tk = a < b;
        3'd7: tk = a >= b;
        default: tk = 0;
      endcase
    end else if (op == OP_JAL) begin
      tk = 1;
      tg = pc + imm;
    end else if (op == OP_JALR) begin
      tk = 1;
      tg = (a + imm) & 32'hFFFF_FFFE;
    end
    mp = (tk != pt) || (tk && tg != ptg);
    ln = pc + 32'd4;
    rd = tk ? tg : ln;
    if (!v) begin
      tk = 0; tg = 0; mp = 0; ln = 0; rd = 0;
    end
    obs_pt = if_pred_taken;
    obs_ptg = if_pred_target;
    obs_tk = ex_taken;
    obs_tg = ex_target;
    obs_ln = ex_link;
    obs_mp = ex_mispredict;
    obs_rd = ex_redirect_pc;
    chk("pred_taken", 32'(if_pred_taken), 32'(m_pt(ipc)));
    chk("pred_target", if_pred_target, m_ptg(ipc));
    chk("ex_taken", 32'(ex_taken), 32'(tk));
    chk("ex_mispredict", 32'(ex_mispredict), 32'(mp));
    chk("ex_redirect", ex_redirect_pc, rd);
    chk("ex_link", ex_link, ln);
    if (!v || ctrl) chk("ex_target", ex_target, tg);
`ifdef BPU_PERF_EN
    chk("perf_branches", perf_branches, m_pb);
    chk("perf_mispredicts", perf_mispredicts, m_pm);
`endif
    @(posedge clk);
    if (r) begin
      m_reset();
    end else begin
      i = midx(pc);
      if (v && ctrl) begin
        if (mhit(pc)) begin
          if (tk) begin
            m_c[i] = (m_c[i] < 3) ? m_c[i] + 1 : 3;
            m_g[i] = tg;
          end else begin
            m_c[i] = (m_c[i] > 0) ? m_c[i] - 1 : 0;
          end
        end else if (tk) begin
          m_v[i] = 1;
          m_t[i] = mtag(pc);
          m_g[i] = tg;
          m_j[i] = op != OP_BRANCH;
          m_c[i] = 1;
        end
      end else if (v && pt && mhit(pc)) begin
        m_v[i] = 0;
      end
`ifdef BPU_PERF_EN
      if (v && ctrl && m_pb != 32'hFFFF_FFFF) m_pb++;
      if (mp && m_pm != 32'hFFFF_FFFF) m_pm++;
`endif
    end
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(0, ipc, 0, OP_OP, 3'd0, 0, 0, 0, 0, 0, 0);
  endtask

  // Branch at pc using the model's own prediction for it.
  task automatic br(input logic [2:0] f3,
                    input logic [31:0] pc,
                    input logic [31:0] a,
                    input logic [31:0] b,
                    input logic [31:0] imm);
    step(0, pc, 1, OP_BRANCH, f3, pc, a, b, imm,
         m_pt(pc), m_ptg(pc));
  endtask

  task automatic jmp(input opcode_e op,
                     input logic [31:0] pc,
                     input logic [31:0] a,
                     input logic [31:0] imm);
    step(0, pc, 1, op, 3'd0, pc, a, 0, imm,
         m_pt(pc), m_ptg(pc));
  endtask

  opcode_e ops [7] = '{OP_BRANCH, OP_BRANCH, OP_BRANCH,
                       OP_JAL, OP_JALR, OP_OP, OP_IMM};
  logic [31:0] vals [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF,
                            32'h8000_0000, 32'd5};

  function automatic logic [31:0] rpc();
    return (32'($urandom_range(0, 15)) << 2)
         | (32'($urandom_range(0, 3)) << 8);
  endfunction

  function automatic logic [31:0] rval();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return vals[$urandom_range(0, 4)];
  endfunction

  initial begin
    logic [31:0] pc, ipc, imm, a;
    opcode_e op;
    m_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    idle(32'h100);
    chk("reset_pt", 32'(obs_pt), 32'd0);
    chk("reset_ptg", obs_ptg, 32'h104);

    step(0, 32'h100, 1, OP_BRANCH, 3'd0, 32'h100,
         5, 5, 32'h20, 0, 0);
    chk("beq_taken", 32'(obs_tk), 32'd1);
    chk("beq_mp", 32'(obs_mp), 32'd1);
    chk("beq_redirect", obs_rd, 32'h120);
    idle(32'h100);
    chk("cnt01_pt", 32'(obs_pt), 32'd0);

    br(3'd0, 32'h100, 5, 5, 32'h20);
    br(3'd0, 32'h100, 5, 5, 32'h20);
    idle(32'h100);
    chk("cnt11_pt", 32'(obs_pt), 32'd1);
    chk("cnt11_ptg", obs_ptg, 32'h120);
    br(3'd0, 32'h100, 5, 5, 32'h20);
    br(3'd0, 32'h100, 5, 6, 32'h20);
    idle(32'h100);
    chk("sat_hi_pt", 32'(obs_pt), 32'd1);
    br(3'd0, 32'h100, 5, 6, 32'h20);
    idle(32'h100);
    chk("cnt01_again", 32'(obs_pt), 32'd0);
    br(3'd0, 32'h100, 5, 6, 32'h20);
    br(3'd0, 32'h100, 5, 6, 32'h20);
    br(3'd0, 32'h100, 5, 5, 32'h20);
    idle(32'h100);
    chk("sat_lo_pt", 32'(obs_pt), 32'd0);

    step(0, 32'h200, 1, OP_JALR, 3'd0, 32'h200,
         32'h1003, 0, 0, 0, 0);
    chk("jalr_tg", obs_tg, 32'h1002);
    chk("jalr_link", obs_ln, 32'h204);
    chk("jalr_mp", 32'(obs_mp), 32'd1);
    jmp(OP_JALR, 32'h200, 32'h1003, 0);
    chk("jalr2_mp", 32'(obs_mp), 32'd0);
    jmp(OP_JALR, 32'h200, 32'h2000, 0);
    chk("jalr3_mp", 32'(obs_mp), 32'd1);
    chk("jalr3_rd", obs_rd, 32'h2000);
    idle(32'h200);
    chk("jalr_retarget", obs_ptg, 32'h2000);

    repeat (3) br(3'd0, 32'h100, 7, 7, 32'h40);
    idle(32'h100);
    chk("alias_pre", 32'(obs_pt), 32'd1);
    jmp(OP_JAL, 32'h100 + 4 * N, 0, 32'h80);
    idle(32'h100);
    chk("alias_evict", 32'(obs_pt), 32'd0);
    step(0, 32'h0, 1, OP_OP, 3'd0, 32'h200, 1, 2, 0,
         1, 32'h280);
    chk("add_mp", 32'(obs_mp), 32'd1);
    chk("add_rd", obs_rd, 32'h204);
    idle(32'h200);
    chk("add_inval", 32'(obs_pt), 32'd0);

    br(3'd4, 32'h300, 32'hFFFF_FFFF, 1, 8);
    chk("blt_taken", 32'(obs_tk), 32'd1);
    br(3'd6, 32'h304, 32'hFFFF_FFFF, 1, 8);
    chk("bltu_taken", 32'(obs_tk), 32'd0);
    br(3'd2, 32'h308, 3, 3, 8);
    chk("bad_f3", 32'(obs_tk), 32'd0);

    jmp(OP_JAL, 32'h400, 0, 32'h10);
    chk("same_idx_pre", 32'(obs_pt), 32'd0);

    step(1, 32'h500, 1, OP_JAL, 3'd0, 32'h500, 0, 0,
         32'h10, 0, 0);
    idle(32'h500);
    chk("rst_prio", 32'(obs_pt), 32'd0);
`ifdef BPU_PERF_EN
    chk("perf_rst_br", perf_branches, 32'd0);
    chk("perf_rst_mp", perf_mispredicts, 32'd0);
`endif

    for (int n = 0; n < 600; n++) begin
      pc = rpc();
      ipc = ($urandom_range(0, 2) == 0) ? pc : rpc();
      op = ops[$urandom_range(0, 6)];
      imm = 32'(($urandom_range(0, 63) - 32) * 4);
      a = rval();
      if ($urandom_range(0, 4) != 0) begin
        step($urandom_range(0, 99) == 0, ipc,
             $urandom_range(0, 9) != 0, op,
             3'($urandom_range(0, 7)), pc, a,
             ($urandom_range(0, 1) == 0) ? a : rval(),
             imm, m_pt(pc), m_ptg(pc));
      end else begin
        step(0, ipc, 1, op, 3'($urandom_range(0, 7)),
             pc, a, rval(), imm,
             1'($urandom_range(0, 1)), rpc());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
